fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_prog_mem.sv | 26 ++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, halt opcode and FSM encoding for the fetch sequencer.
// Also provides a small opcode-decode helper used by the top level.
package fetch_sequencer_pkg;

  localparam int         WIDTH   = 20;
  localparam int         DEPTH   = 32;
  localparam int         ADDR_W  = $clog2(DEPTH);
  localparam logic [4:0] HALT_OP = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic is_halt(input logic [WIDTH-1:0] ins);
    return ins[4:0] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_sequencer_prog_mem.sv
// Program memory: single write port, combinational read port.
// Contents survive reset so a loaded program can be replayed.
module fetch_sequencer_prog_mem
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; resetting it would turn
  // it into a flop bank and would also wipe the program we must retain.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED FSM, pc, and a one-entry
// output register toward decode with stall, redirect and halt handling.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             prog_we,
  input  logic [4:0]       prog_addr,
  input  logic [WIDTH-1:0] prog_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_pc,
  output logic             halted
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic             r_instr_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_instr_nxt;
  logic [WIDTH-1:0] w_instr_pc_nxt;
  logic             w_instr_valid_nxt;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_mem_rdata;
  logic             w_transfer;

  fetch_sequencer_prog_mem u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr[ADDR_W-1:0]),
    .i_wdata (prog_data),
    .i_raddr (r_pc[ADDR_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

  assign w_transfer = r_instr_valid & dec_ready;

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_mem_we          = 1'b0;

    case (r_state)
      ST_IDLE, ST_HALTED: begin
        w_mem_we          = prog_we;
        w_instr_valid_nxt = 1'b0;
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
        end
      end

      ST_RUN: begin
        // Halt on transfer beats redirect; redirect beats advance and stall.
        if (w_transfer && is_halt(r_instr)) begin
          w_state_nxt       = ST_HALTED;
          w_instr_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          w_pc_nxt          = redirect_target;
          w_instr_valid_nxt = 1'b0;
        end else if (!r_instr_valid || w_transfer) begin
          w_instr_nxt       = w_mem_rdata;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + WIDTH'(1);
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_instr_valid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = (r_state == ST_HALTED);

endmodule
